// File: rtl/chnlnk_frame_builder.sv
// chnlnk_frame_builder
// Purpose : Builds the 16-bit word stream sent to the channel-link serializer.
//           Each frame is 100 words: words 0..95 are sample words popped from
//           an FWFT FIFO, then four tail words follow:
//             96 {4'hD, FRM_CNT}                   (CRC accumulated)
//             97 {4'hE, 11'h000, SEQ_ERR}          (CRC accumulated)
//             98 CRC-16/0x1021 of words 0..97      (16'hC5C5 without CRC)
//             99 {4'hF, 12'hFFF ^ FRM_CNT}
//           The comma word IDLE_WORD is sent whenever no frame word is valid.
// Latency : exactly one i_clk from i_valid/i_seq/i_fifo_dout to o_tx_*.
// Backpressure: none; the serializer accepts one word every cycle.
//
// Build option: define CHNLNK_CRC_EN to compile in the CRC register. When it
// is undefined there is no CRC register and word 98 is the constant 16'hC5C5.
//
// Ports:
//   i_clk        sole clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_clr_crc    frame-start strobe: clears CRC and expected-sequence counter
//   i_valid      a frame word is present this cycle
//   i_rd         this frame word is sample data from i_fifo_dout
//   i_seq        word index within the frame, 0..99
//   i_last_wrd   end-of-event strobe, advances the event counter
//   i_fifo_dout  sample data, valid in the same cycle as i_rd
//   o_tx_data    registered word to the serializer
//   o_tx_k       registered; high when o_tx_data is IDLE_WORD (comma)
//   o_tx_vld     registered; high when o_tx_data is a frame word
//   o_frm_cnt    count of completed events (wraps at 12 bits)
//   o_seq_err    sticky protocol-error flag, cleared only by reset

module chnlnk_frame_builder #(
    parameter logic [15:0] IDLE_WORD = 16'h50BC
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr_crc,
    input  logic        i_valid,
    input  logic        i_rd,
    input  logic [6:0]  i_seq,
    input  logic        i_last_wrd,
    input  logic [15:0] i_fifo_dout,
    output logic [15:0] o_tx_data,
    output logic        o_tx_k,
    output logic        o_tx_vld,
    output logic [11:0] o_frm_cnt,
    output logic        o_seq_err
);

    localparam logic [6:0] SEQ_LAST_DATA = 7'd95;
    localparam logic [6:0] SEQ_HDR       = 7'd96;
    localparam logic [6:0] SEQ_STAT      = 7'd97;
    localparam logic [6:0] SEQ_CRC       = 7'd98;
    localparam logic [6:0] SEQ_TAIL      = 7'd99;

    logic [15:0] r_tx_data;
    logic        r_tx_k;
    logic        r_tx_vld;
    logic [11:0] r_frm_cnt;
    logic        r_seq_err;
    logic [6:0]  r_exp_seq;

    logic [15:0] w_word;
    logic        w_word_vld;
    logic [15:0] w_crc_word;
    logic        w_proto_err;

    // ------------------------------------------------------------------
    // Word selection. Protocol-violating words are still emitted: RD=1
    // always selects FIFO data, and a non-data index outside 96..99 falls
    // back to the comma word.
    // ------------------------------------------------------------------
    always_comb begin
        w_word     = IDLE_WORD;
        w_word_vld = 1'b0;
        if (i_valid) begin
            if (i_rd) begin
                w_word     = i_fifo_dout;
                w_word_vld = 1'b1;
            end else begin
                case (i_seq)
                    SEQ_HDR: begin
                        w_word     = {4'hD, r_frm_cnt};
                        w_word_vld = 1'b1;
                    end
                    SEQ_STAT: begin
                        w_word     = {4'hE, 11'h000, r_seq_err};
                        w_word_vld = 1'b1;
                    end
                    SEQ_CRC: begin
                        w_word     = w_crc_word;
                        w_word_vld = 1'b1;
                    end
                    SEQ_TAIL: begin
                        w_word     = {4'hF, 12'hFFF ^ r_frm_cnt};
                        w_word_vld = 1'b1;
                    end
                    default: begin
                        w_word     = IDLE_WORD;
                        w_word_vld = 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef CHNLNK_CRC_EN
    // ------------------------------------------------------------------
    // CRC-16, poly 0x1021, init 16'hFFFF, one full word per cycle, MSB
    // first, no final XOR. Sample words and tail words 96/97 are folded
    // in; the CRC word itself and word 99 are not.
    // ------------------------------------------------------------------
    logic [15:0] r_crc;
    logic        w_crc_acc;

    function automatic logic [15:0] crc16_word(input logic [15:0] crc,
                                               input logic [15:0] dat);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ dat[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    assign w_crc_acc  = i_valid && (i_rd || (i_seq == SEQ_HDR) || (i_seq == SEQ_STAT));
    assign w_crc_word = r_crc;

    // A frame-start strobe wins over accumulation of a coincident word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_crc <= 16'hFFFF;
        end else if (i_clr_crc) begin
            r_crc <= 16'hFFFF;
        end else if (w_crc_acc) begin
            r_crc <= crc16_word(r_crc, w_word);
        end
    end
`else
    assign w_crc_word = 16'hC5C5;
`endif

    // ------------------------------------------------------------------
    // Sequence checking. The expected index counts valid words since the
    // last frame-start strobe and sticks at the final index.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_exp_seq <= 7'd0;
        end else if (i_clr_crc) begin
            r_exp_seq <= 7'd0;
        end else if (i_valid && (r_exp_seq != SEQ_TAIL)) begin
            r_exp_seq <= r_exp_seq + 7'd1;
        end
    end

    assign w_proto_err = (i_valid && (i_seq != r_exp_seq))
                       || (i_valid && i_rd && (i_seq > SEQ_LAST_DATA))
                       || (i_valid && !i_rd && (i_seq < SEQ_HDR))
                       || (i_seq > SEQ_TAIL);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_seq_err <= 1'b0;
        end else if (w_proto_err) begin
            r_seq_err <= 1'b1;
        end
    end

    // Event counter; a coincident tail word already sampled the old value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frm_cnt <= 12'h000;
        end else if (i_last_wrd) begin
            r_frm_cnt <= r_frm_cnt + 12'h001;
        end
    end

    // Output register stage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx_data <= IDLE_WORD;
            r_tx_k    <= 1'b1;
            r_tx_vld  <= 1'b0;
        end else begin
            r_tx_data <= w_word;
            r_tx_k    <= ~w_word_vld;
            r_tx_vld  <= w_word_vld;
        end
    end

    assign o_tx_data = r_tx_data;
    assign o_tx_k    = r_tx_k;
    assign o_tx_vld  = r_tx_vld;
    assign o_frm_cnt = r_frm_cnt;
    assign o_seq_err = r_seq_err;

endmodule

// File: tb/tb_chnlnk_frame_builder.sv
// tb_chnlnk_frame_builder
// Purpose : directed self-checking bench for chnlnk_frame_builder.
// Latency : outputs checked 1 ns after the edge that registers each word.
// Backpressure: none; one stimulus word per cycle.

module tb_chnlnk_frame_builder;

    logic        clk;
    logic        rst;
    logic        clr_crc;
    logic        valid;
    logic        rd;
    logic [6:0]  seq;
    logic        last_wrd;
    logic [15:0] fifo_dout;
    logic [15:0] tx_data;
    logic        tx_k;
    logic        tx_vld;
    logic [11:0] frm_cnt;
    logic        seq_err;

    int n_checks;
    int n_fail;

    chnlnk_frame_builder dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_clr_crc   (clr_crc),
        .i_valid     (valid),
        .i_rd        (rd),
        .i_seq       (seq),
        .i_last_wrd  (last_wrd),
        .i_fifo_dout (fifo_dout),
        .o_tx_data   (tx_data),
        .o_tx_k      (tx_k),
        .o_tx_vld    (tx_vld),
        .o_frm_cnt   (frm_cnt),
        .o_seq_err   (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are read 1 ns after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference CRC: whole-word XOR into the register, then 16 shifts.
    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c ^ d;
        for (int b = 0; b < 16; b++) begin
            if (r[15]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else       r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_data"}, 32'(tx_data), 32'h50BC);
        chk({tag, "_k"},    32'(tx_k),    32'd1);
        chk({tag, "_vld"},  32'(tx_vld),  32'd0);
    endtask

    // One full frame preceded by a frame-start strobe. Sample word k is
    // seed+k. With skip set, index 41 is never sent (40 -> 42).
    task automatic run_frame(input string tag, input logic [15:0] seed, input bit skip,
                             input bit last99, input logic [11:0] frm,
                             input logic err97, input logic err_end);
        logic [15:0] crc_m;
        logic [15:0] d;
        logic [15:0] exp_w;
        crc_m = 16'hFFFF;
        clr_crc = 1'b1; valid = 1'b0; rd = 1'b0; seq = 7'd0; last_wrd = 1'b0;
        step();
        chk_idle({tag, "_clr"});
        clr_crc = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (skip && k == 41) continue;
            valid    = 1'b1;
            seq      = 7'(k);
            last_wrd = last99 && (k == 99);
            if (k < 96) begin
                rd        = 1'b1;
                d         = seed + 16'(k);
                fifo_dout = d;
                exp_w     = d;
                crc_m     = crc_model(crc_m, d);
            end else begin
                rd        = 1'b0;
                fifo_dout = 16'hDEAD;
                case (k)
                    96: begin
                        exp_w = {4'hD, frm};
                        crc_m = crc_model(crc_m, exp_w);
                    end
                    97: begin
                        exp_w = {4'hE, 11'h000, err97};
                        crc_m = crc_model(crc_m, exp_w);
                    end
`ifdef CHNLNK_CRC_EN
                    98: exp_w = crc_m;
`else
                    98: exp_w = 16'hC5C5;
`endif
                    default: exp_w = {4'hF, 12'hFFF ^ frm};
                endcase
            end
            step();
            chk($sformatf("%s_w%0d_data", tag, k), 32'(tx_data), 32'(exp_w));
            chk($sformatf("%s_w%0d_vld", tag, k),  32'(tx_vld),  32'd1);
            chk($sformatf("%s_w%0d_k", tag, k),    32'(tx_k),    32'd0);
        end
        valid = 1'b0; rd = 1'b0; seq = 7'd0; last_wrd = 1'b0;
        step();
        chk_idle({tag, "_end"});
        chk({tag, "_seq_err"}, 32'(seq_err), 32'(err_end));
        chk({tag, "_frm_cnt"}, 32'(frm_cnt), 32'(frm + 12'(last99)));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; clr_crc = 1'b0; valid = 1'b0; rd = 1'b0;
        seq = 7'd0; last_wrd = 1'b0; fifo_dout = 16'h0000;

        // Reset state while reset is held.
        step();
        step();
        chk_idle("rst");
        chk("rst_frm_cnt", 32'(frm_cnt), 32'd0);
        chk("rst_seq_err", 32'(seq_err), 32'd0);
        rst = 1'b0;

        // Ten idle cycles.
        for (int i = 0; i < 10; i++) begin
            step();
            chk_idle($sformatf("idle%0d", i));
        end

        // Clean frame, data 0x0000..0x005F, event count 0.
        run_frame("fA", 16'h0000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
        // Same frame again, end-of-event coincident with word 99.
        run_frame("fB", 16'h1234, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0);
        // Next event: word 96 = D001, word 99 = FFFE.
        run_frame("fC", 16'hA5A0, 1'b0, 1'b0, 12'h001, 1'b0, 1'b0);
        // Skipped index 40 -> 42: flag sets before word 97 of this frame.
        run_frame("fE", 16'h0F00, 1'b1, 1'b0, 12'h001, 1'b1, 1'b1);
        // Flag survives the frame-start strobe: word 97 = E001.
        run_frame("fF", 16'h7700, 1'b0, 1'b0, 12'h001, 1'b1, 1'b1);

        // Reset in the middle of a frame, at index 50.
        clr_crc = 1'b1; step(); clr_crc = 1'b0;
        for (int k = 0; k <= 50; k++) begin
            valid = 1'b1; rd = 1'b1; seq = 7'(k); fifo_dout = 16'h3300 + 16'(k);
            step();
        end
        chk("mid_w50_data", 32'(tx_data), 32'h3332);
        valid = 1'b1; rd = 1'b1; seq = 7'd51; fifo_dout = 16'h3333;
        rst = 1'b1;
        #1;
        chk_idle("arst");
        chk("arst_frm_cnt", 32'(frm_cnt), 32'd0);
        chk("arst_seq_err", 32'(seq_err), 32'd0);
        valid = 1'b0; rd = 1'b0; seq = 7'd0;
        step();
        rst = 1'b0;
        step();
        chk_idle("post_rst");
        // Full frame after reset; CRC restarts from FFFF.
        run_frame("fR", 16'h0000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);

        // Event counter wrap.
        last_wrd = 1'b1;
        for (int i = 0; i < 4095; i++) step();
        chk("wrap_fff", 32'(frm_cnt), 32'hFFF);
        step();
        chk("wrap_000", 32'(frm_cnt), 32'h000);
        last_wrd = 1'b0;
        step();
        chk_idle("final");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
